// File: rtl/alu181_reg.sv
// alu181_reg: 4-bit 74181-compatible ALU with every output registered on clk_i.
module alu181_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_control_i,
    input  logic [3:0] select_input_i,
    input  logic [3:0] operand_a_i,
    input  logic [3:0] operand_b_i,
    input  logic       carry_input_i,
    output logic [3:0] function_output_o,
    output logic       generate_output_o,
    output logic       propagate_output_o,
    output logic       carry_output_o,
    output logic       cmp_output_o
);
    logic [3:0] u, v, f;
    logic [4:0] sum;
    logic       gint, pint;
    assign u = operand_a_i | (operand_b_i & {4{select_input_i[0]}}) | (~operand_b_i & {4{select_input_i[1]}});
    assign v = (operand_a_i & operand_b_i & {4{select_input_i[3]}}) | (operand_a_i & ~operand_b_i & {4{select_input_i[2]}});
    assign sum = {1'b0, u} + {1'b0, v} + {4'b0, ~carry_input_i};
    // V implies U bitwise, so V is the per-bit generate and U the per-bit propagate
    assign gint = v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]);
    assign pint = &u;
    assign f = mode_control_i ? ~(u ^ v) : sum[3:0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            function_output_o  <= 4'h0;
            generate_output_o  <= 1'b1;
            propagate_output_o <= 1'b1;
            carry_output_o     <= 1'b1;
            cmp_output_o       <= 1'b0;
        end else begin
            function_output_o  <= f;
            generate_output_o  <= ~gint;
            propagate_output_o <= ~pint;
            carry_output_o     <= ~(gint | (pint & ~carry_input_i));
            cmp_output_o       <= &f;
        end
    end
endmodule

// File: tb/tb_alu181_reg.sv
// tb_alu181_reg: directed and pipelined checks of alu181_reg; outputs packed as {cmp, cout, p, g, f}.
module tb_alu181_reg;
    logic       clk = 0, rst = 0, m = 0, cn = 1;
    logic [3:0] s = 0, a = 0, b = 0;
    logic [3:0] f;
    logic       g, p, co, cmp;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q;
    logic [7:0] obs;

    alu181_reg dut (
        .clk_i(clk), .rst_i(rst), .mode_control_i(m), .select_input_i(s),
        .operand_a_i(a), .operand_b_i(b), .carry_input_i(cn),
        .function_output_o(f), .generate_output_o(g), .propagate_output_o(p),
        .carry_output_o(co), .cmp_output_o(cmp)
    );

    always #5 clk = ~clk;
    assign obs = {cmp, co, p, g, f};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic apply(input logic mi, input logic [3:0] si, input logic [3:0] ai, input logic [3:0] bi, input logic ci);
        m = mi; s = si; a = ai; b = bi; cn = ci;
        @(posedge clk);
        #1;
    endtask

    // Reference built from the 74181 function tables: U chosen by S[1:0], V by S[3:2]
    function automatic logic [7:0] model(input logic mi, input logic [3:0] si, input logic [3:0] ai, input logic [3:0] bi, input logic ci);
        logic [3:0] uu, vv, ff;
        logic [4:0] sm, raw;
        uu = si[1:0] == 2'd0 ? ai : si[1:0] == 2'd1 ? (ai | bi) : si[1:0] == 2'd2 ? (ai | ~bi) : 4'hF;
        vv = si[3:2] == 2'd0 ? 4'h0 : si[3:2] == 2'd1 ? (ai & ~bi) : si[3:2] == 2'd2 ? (ai & bi) : ai;
        raw = {1'b0, uu} + {1'b0, vv};
        sm = raw + {4'b0, ~ci};
        ff = mi ? ~(uu ^ vv) : sm[3:0];
        return {&ff, ~sm[4], uu != 4'hF, ~raw[4], ff};
    endfunction

    logic [3:0] logic_tab [16] = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
                                   4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC};

    initial begin
        rst = 1;
        apply(1'b0, 4'h9, 4'hF, 4'hF, 1'b0);
        check("reset", obs, 8'h70);
        rst = 0;
        apply(1'b1, 4'hF, 4'h5, 4'h0, 1'b1);
        check("logic_a_after_reset", {4'h0, f}, 8'h05);

        apply(1'b0, 4'h9, 4'h5, 4'h3, 1'b1);
        check("add_5_3", obs, 8'h78);
        apply(1'b0, 4'h9, 4'hF, 4'h1, 1'b0);
        check("add_wrap", obs, 8'h01);
        apply(1'b0, 4'h6, 4'h7, 4'h7, 1'b0);
        check("sub_eq_cin", obs, 8'h10);
        apply(1'b0, 4'h6, 4'h7, 4'h7, 1'b1);
        check("sub_eq_cmp", obs, 8'hDF);
        apply(1'b0, 4'h6, 4'h7, 4'h8, 1'b1);
        check("sub_ne_cmp", obs, 8'h7E);
        apply(1'b0, 4'h3, 4'h9, 4'h2, 1'b1);
        check("minus_one", {4'h0, f}, 8'h0F);
        apply(1'b0, 4'hC, 4'h6, 4'h0, 1'b1);
        check("a_plus_a", {4'h0, f}, 8'h0C);
        apply(1'b0, 4'hF, 4'h0, 4'h0, 1'b1);
        check("a_minus_1_wrap", {co, 3'b0, f}, 8'h8F);

        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 2; c++) begin
                apply(1'b1, 4'(i), 4'hC, 4'hA, c[0]);
                check($sformatf("logic_s%0d_cn%0d", i, c), {3'b0, cmp, f}, {3'b0, logic_tab[i] == 4'hF, logic_tab[i]});
            end
        end

        // Inputs change every cycle; a mid-cycle glitch before the sampled value must not matter
        for (int i = 0; i < 16; i++) begin
            logic       rm, rc;
            logic [3:0] rs, ra, rb;
            rm = 1'($urandom); rc = 1'($urandom);
            rs = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
            rst = (i == 8);
            exp_q = rst ? 8'h70 : model(rm, rs, ra, rb, rc);
            a = ~ra;
            #2;
            apply(rm, rs, ra, rb, rc);
            check($sformatf("pipe_%0d", i), obs, exp_q);
        end
        rst = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
